// File: rtl/rv_pkg.sv
// Shared RV32I load/store definitions: funct3 encodings, sequencer states and
// size/legality decode helpers.
package rv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} lsu_state_t;

  // Access size in bytes; 0 marks an undefined size encoding.
  function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      2'b10:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic is_legal(input logic we, input logic [2:0] funct3);
    if (we) return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
           (funct3 == F3_BU) || (funct3 == F3_HU);
  endfunction

endpackage

// File: rtl/rv_load_ext.sv
// Combinational load-data extract and sign/zero extension from the beat
// accumulator, using the address byte offset within a memory word.
module rv_load_ext
  import rv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int MEM_W = 8
) (
  input  logic [XLEN-1:0] acc_i,
  input  logic [1:0]      lsb_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] data_o
);

  // Only offsets inside one memory beat select a lane; wider accesses are aligned.
  localparam logic [1:0] LMASK = 2'(MEM_W / 8 - 1);

  logic [XLEN-1:0] sh;

  always_comb begin
    sh = acc_i >> {(lsb_i & LMASK), 3'b000};
    case (funct3_i)
      F3_B:    data_o = {{(XLEN-8){sh[7]}}, sh[7:0]};
      F3_H:    data_o = {{(XLEN-16){sh[15]}}, sh[15:0]};
      F3_W:    data_o = sh;
      F3_BU:   data_o = {{(XLEN-8){1'b0}}, sh[7:0]};
      F3_HU:   data_o = {{(XLEN-16){1'b0}}, sh[15:0]};
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/rv_lsu_seq.sv
// Load/store sequencer: splits one core access into little-endian MEM_W-bit
// memory beats, reassembles load data and flags misaligned/illegal requests.
module rv_lsu_seq
  import rv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int MEM_W  = 8
) (
  input  logic              sysclk,
  input  logic              sysreset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [MEM_W-1:0]  mem_wdata,
  input  logic              mem_ack,
  input  logic [MEM_W-1:0]  mem_rdata
);

  localparam int BPB   = MEM_W / 8;
  localparam int NLANE = XLEN / MEM_W;
  localparam logic [ADDR_W-1:0] BPB_A      = ADDR_W'(BPB);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BPB - 1);

  lsu_state_t        state_q, state_d;
  logic [2:0]        beat_q, beat_d;
  logic [XLEN-1:0]   acc_q, acc_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;

  logic [2:0]        size_in;
  logic              misal;
  logic [XLEN-1:0]   rep;
  logic [XLEN-1:0]   ext;

  function automatic logic [2:0] num_beats(input logic [2:0] f3);
    int n;
    n = (int'(size_bytes(f3)) * 8) / MEM_W;
    if (n < 1) n = 1;
    return 3'(n);
  endfunction

  assign size_in = size_bytes(req_funct3);
  assign misal   = (req_addr[1:0] & 2'(size_in - 3'd1)) != 2'b00;

  // Store data replicated across the word so any lane a beat selects carries it.
  always_comb begin
    case (f3_q[1:0])
      2'b00:   rep = {(XLEN/8){wdata_q[7:0]}};
      2'b01:   rep = {(XLEN/16){wdata_q[15:0]}};
      default: rep = wdata_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    acc_d      = acc_q;
    err_d      = err_q;
    we_d       = we_q;
    f3_d       = f3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    req_ready  = 1'b0;
    mem_req    = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          beat_d  = 3'd0;
          acc_d   = '0;
          if (!is_legal(req_we, req_funct3) || misal) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          for (int k = 0; k < NLANE; k++)
            if (beat_q == 3'(k)) acc_d[k*MEM_W +: MEM_W] = mem_rdata;
          beat_d = beat_q + 3'd1;
          if (beat_q == num_beats(f3_q) - 3'd1) state_d = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == ACCESS) begin
      mem_we   = we_q;
      mem_addr = (addr_q & ALIGN_MASK) + ADDR_W'(beat_q) * BPB_A;
      for (int k = 0; k < NLANE; k++)
        if (beat_q == 3'(k)) mem_wdata = rep[k*MEM_W +: MEM_W];
    end
  end

  rv_load_ext #(.XLEN(XLEN), .MEM_W(MEM_W)) u_ext (
    .acc_i    (acc_q),
    .lsb_i    (addr_q[1:0]),
    .funct3_i (f3_q),
    .data_o   (ext)
  );

  assign resp_err   = (state_q == RESP) && err_q;
  assign resp_rdata = (state_q == RESP && !err_q && !we_q) ? ext : '0;

  always_ff @(posedge sysclk) begin
    if (sysreset) begin
      state_q <= IDLE;
      beat_q  <= 3'd0;
      acc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
    end
  end

  // Request fields are only meaningful while a request is in flight.
  always_ff @(posedge sysclk) begin
    we_q    <= we_d;
    f3_q    <= f3_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

endmodule

// File: tb/tb_rv_lsu_seq.sv
// Bench for rv_lsu_seq: three instances (MEM_W = 8, 16, 32) against a
// transaction-level memory/response model, plus directed literal checks.
module tb_rv_lsu_seq;

  logic clk = 1'b0;
  initial forever #5 clk = ~clk;

  logic        sysreset;
  logic        req_valid_a [3];
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready_a [3], resp_valid_a [3], resp_err_a [3];
  logic        mem_req_a [3], mem_we_a [3], mem_ack_a [3];
  logic [31:0] resp_rdata_a [3], mem_addr_a [3], mem_wdata_a [3], mem_rdata_a [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int MW = 8 << g;
    logic [MW-1:0] wd;
    rv_lsu_seq #(.XLEN(32), .ADDR_W(32), .MEM_W(MW)) u_dut (
      .sysclk(clk), .sysreset(sysreset),
      .req_valid(req_valid_a[g]), .req_ready(req_ready_a[g]),
      .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid_a[g]), .resp_rdata(resp_rdata_a[g]), .resp_err(resp_err_a[g]),
      .mem_req(mem_req_a[g]), .mem_we(mem_we_a[g]), .mem_addr(mem_addr_a[g]),
      .mem_wdata(wd), .mem_ack(mem_ack_a[g]), .mem_rdata(mem_rdata_a[g][MW-1:0])
    );
    assign mem_wdata_a[g] = 32'(wd);
  end

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  mem [3][4096];
  logic        exp_pending [3], exp_we [3], exp_err [3];
  int          exp_nb [3], exp_bidx [3], wcnt [3];
  logic [31:0] exp_rdata [3], exp_baddr [3][4], exp_bwdata [3][4];
  int          wmode;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Expected outcome of one accepted request, straight from the access rules.
  task automatic model_accept(input int d, input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wd);
    int sz, bpb, nb;
    logic legal;
    logic [31:0] v, bw;
    bpb = 1 << d;
    sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 0;
    legal = we ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)
               : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    exp_bidx[d] = 0;
    exp_we[d]   = we;
    if (!legal || (addr % sz) != 0) begin
      exp_err[d] = 1'b1; exp_rdata[d] = 32'h0; exp_nb[d] = 0;
    end else begin
      exp_err[d] = 1'b0;
      nb = sz / bpb;
      if (nb < 1) nb = 1;
      exp_nb[d] = nb;
      for (int k = 0; k < nb; k++) begin
        exp_baddr[d][k] = (sz < bpb) ? addr - (addr % bpb) : addr + k * bpb;
        bw = 32'h0;
        for (int j = 0; j < bpb; j++) bw[8*j +: 8] = wd[8*((k*bpb + j) % sz) +: 8];
        exp_bwdata[d][k] = bw;
      end
      v = 32'h0;
      for (int i = 0; i < sz; i++) v[8*i +: 8] = mem[d][(addr + i) & 32'hFFF];
      if (we)              exp_rdata[d] = 32'h0;
      else if (f3 == 3'd0) exp_rdata[d] = {{24{v[7]}}, v[7:0]};
      else if (f3 == 3'd1) exp_rdata[d] = {{16{v[15]}}, v[15:0]};
      else                 exp_rdata[d] = v;
    end
  endtask

  // Memory responder and per-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        logic ack, ereq, eresp;
        int bpb;
        bpb  = 1 << d;
        ereq = exp_pending[d] && (exp_bidx[d] < exp_nb[d]);
        if (!sysreset) begin
          chk("req_ready", req_ready_a[d], !exp_pending[d]);
          chk("mem_req", mem_req_a[d], ereq);
          if (ereq && mem_req_a[d]) begin
            chk("mem_addr", mem_addr_a[d], exp_baddr[d][exp_bidx[d]]);
            chk("mem_we", mem_we_a[d], exp_we[d]);
            if (exp_we[d]) chk("mem_wdata", mem_wdata_a[d], exp_bwdata[d][exp_bidx[d]]);
          end
          eresp = exp_pending[d] && (exp_bidx[d] == exp_nb[d]);
          chk("resp_valid", resp_valid_a[d], eresp);
          if (eresp && resp_valid_a[d]) begin
            chk("resp_err", resp_err_a[d], exp_err[d]);
            chk("resp_rdata", resp_rdata_a[d], exp_rdata[d]);
            exp_pending[d] = 1'b0;
          end
        end
        if (wmode == 0) ack = 1'b1;
        else if (wmode == 1) ack = 1'($urandom % 2);
        else begin
          ack = 1'b0;
          if (mem_req_a[d]) begin
            if (wcnt[d] < 3) wcnt[d]++;
            else begin ack = 1'b1; wcnt[d] = 0; end
          end
        end
        mem_rdata_a[d] = 32'h0;
        for (int j = 0; j < bpb; j++)
          mem_rdata_a[d][8*j +: 8] = mem[d][(mem_addr_a[d] + j) & 32'hFFF];
        if (!sysreset && mem_req_a[d] && ack && ereq) begin
          if (mem_we_a[d])
            for (int j = 0; j < bpb; j++)
              mem[d][(mem_addr_a[d] + j) & 32'hFFF] = mem_wdata_a[d][8*j +: 8];
          exp_bidx[d]++;
        end
        mem_ack_a[d] = ack;
      end
    end
  end

  task automatic do_txn(input int d, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic er,
                        output logic fr_req, output logic fr_we,
                        output logic [31:0] fr_addr, output logic [31:0] fr_wdata);
    int g;
    @(posedge clk); #1;
    g = 0;
    while (!req_ready_a[d] && g < 100) begin @(posedge clk); #1; g++; end
    if (g >= 100) chk("ready_timeout", 32'(g), 32'd0);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    req_valid_a[d] = 1'b1;
    model_accept(d, we, f3, addr, wd);
    @(posedge clk); #1;
    req_valid_a[d] = 1'b0;
    exp_pending[d] = 1'b1;
    fr_req = mem_req_a[d]; fr_we = mem_we_a[d];
    fr_addr = mem_addr_a[d]; fr_wdata = mem_wdata_a[d];
    lat = 1;
    while (!resp_valid_a[d] && lat < 200) begin
      req_we = 1'($urandom); req_funct3 = 3'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 200) chk("resp_timeout", 32'(lat), 32'd0);
    rd = resp_rdata_a[d];
    er = resp_err_a[d];
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, g;
    logic [31:0] rd, fa, fw;
    logic er, fq, fwe;
    for (int d = 0; d < 3; d++) begin
      for (int a = 0; a < 4096; a++) mem[d][a] = 8'($urandom);
      req_valid_a[d] = 1'b0; mem_ack_a[d] = 1'b0; mem_rdata_a[d] = 32'h0;
      exp_pending[d] = 1'b0; exp_nb[d] = 0; exp_bidx[d] = 0; wcnt[d] = 0;
    end
    mem[0][12'h100] = 8'h93; mem[0][12'h101] = 8'h00;
    mem[0][12'h102] = 8'h70; mem[0][12'h103] = 8'h00;
    mem[0][12'h201] = 8'h80;
    mem[1][12'h300] = 8'h11; mem[1][12'h301] = 8'h22;
    mem[1][12'h302] = 8'h33; mem[1][12'h303] = 8'h44;
    req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
    wmode = 0;

    sysreset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_req_ready", req_ready_a[d], 32'd1);
      chk("rst_ctrl", {resp_valid_a[d], resp_err_a[d], mem_req_a[d], mem_we_a[d]}, 32'd0);
      chk("rst_data", resp_rdata_a[d] | mem_addr_a[d] | mem_wdata_a[d], 32'd0);
    end
    sysreset = 1'b0;

    do_txn(0, 1'b0, 3'b010, 32'h100, 32'h0, lat, rd, er, fq, fwe, fa, fw);
    chk("lw8_rdata", rd, 32'h00700093);
    chk("lw8_latency", 32'(lat), 32'd5);
    chk("lw8_first_beat", fa, 32'h100);

    do_txn(0, 1'b0, 3'b000, 32'h201, 32'h0, lat, rd, er, fq, fwe, fa, fw);
    chk("lb8_rdata", rd, 32'hFFFFFF80);
    chk("lb8_latency", 32'(lat), 32'd2);
    do_txn(0, 1'b0, 3'b100, 32'h201, 32'h0, lat, rd, er, fq, fwe, fa, fw);
    chk("lbu8_rdata", rd, 32'h00000080);

    do_txn(2, 1'b1, 3'b001, 32'h002, 32'h0000BEEF, lat, rd, er, fq, fwe, fa, fw);
    chk("sh32_beat", {29'h0, fq, fwe, 1'b0} | fa, 32'h6);
    chk("sh32_wdata_hi", {16'h0, fw[31:16]}, 32'h0000BEEF);
    chk("sh32_latency", 32'(lat), 32'd2);

    do_txn(0, 1'b0, 3'b001, 32'h003, 32'h0, lat, rd, er, fq, fwe, fa, fw);
    chk("lh_misal_err", er, 32'd1);
    chk("lh_misal_latency", 32'(lat), 32'd1);
    chk("lh_misal_no_beat", fq, 32'd0);
    do_txn(1, 1'b0, 3'b011, 32'h300, 32'h0, lat, rd, er, fq, fwe, fa, fw);
    chk("f3_011_err", er, 32'd1);

    wmode = 2;
    do_txn(1, 1'b0, 3'b010, 32'h300, 32'h0, lat, rd, er, fq, fwe, fa, fw);
    chk("lw16_wait_rdata", rd, 32'h44332211);
    chk("lw16_wait_latency", 32'(lat), 32'd9);
    wmode = 0;

    @(posedge clk); #1;
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100; req_valid_a[0] = 1'b1;
    model_accept(0, 1'b0, 3'b010, 32'h100, 32'h0);
    @(posedge clk); #1;
    req_valid_a[0] = 1'b0;
    exp_pending[0] = 1'b1;
    g = 0;
    while (exp_bidx[0] < 2 && g < 50) begin @(posedge clk); #1; g++; end
    if (g >= 50) chk("rstmid_timeout", 32'(g), 32'd0);
    sysreset = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_mem_req", mem_req_a[0], 32'd0);
    chk("rstmid_req_ready", req_ready_a[0], 32'd1);
    chk("rstmid_resp_valid", resp_valid_a[0], 32'd0);
    sysreset = 1'b0;
    exp_pending[0] = 1'b0;
    repeat (6) @(posedge clk);
    do_txn(0, 1'b0, 3'b010, 32'h100, 32'h0, lat, rd, er, fq, fwe, fa, fw);
    chk("post_rst_lw_rdata", rd, 32'h00700093);
    chk("post_rst_lw_latency", 32'(lat), 32'd5);

    for (int t = 0; t < 300; t++) begin
      int d;
      logic [31:0] addr;
      d = int'($urandom % 3);
      addr = $urandom % 1024;
      if ($urandom % 4 != 0) addr = addr & ~32'h3;
      wmode = int'($urandom % 3);
      do_txn(d, 1'($urandom), 3'($urandom), addr, $urandom, lat, rd, er, fq, fwe, fa, fw);
    end
    wmode = 0;
    repeat (4) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rv_lsu_seq.md
Name: rv_lsu_seq

Overview:
- Parametrised load/store sequencer between the RV32I core datapath and a narrow data memory port.
- Takes one core load/store request (funct3-encoded size/sign) and splits it into MEM_W-bit memory beats, little-endian.
- For loads, reassembles the beats and sign- or zero-extends the result to XLEN.
- Generalises the fixed 8-bit dmem_dout/dmem_din link to a configurable bus width, adds handshakes, and adds misalignment and illegal-size detection.

Parameters:
XLEN, 32, core data width
ADDR_W, 32, byte address width
MEM_W, 8, memory beat width in bits; legal values 8, 16, 32

Ports:
sysclk  in  1  clock
sysreset  in  1  synchronous active-high reset
req_valid  in  1  core request valid
req_ready  out  1  sequencer can accept a request
req_we  in  1  1=store, 0=load
req_funct3  in  3  RV32I load/store funct3
req_addr  in  ADDR_W  byte address
req_wdata  in  XLEN  store data (LSBs used)
resp_valid  out  1  one-cycle pulse: access complete
resp_rdata  out  XLEN  extended load data (0 for stores/errors)
resp_err  out  1  valid with resp_valid: misaligned or illegal funct3
mem_req  out  1  memory beat request
mem_we  out  1  beat is a write
mem_addr  out  ADDR_W  beat byte address
mem_wdata  out  MEM_W  beat write data
mem_ack  in  1  beat accepted/completed; read data valid same cycle
mem_rdata  in  MEM_W  beat read data

Behaviour:
- Reset is synchronous, sampled on the rising sysclk edge.
- Reset state: IDLE. req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; mem_req=0; mem_we=0; mem_addr=0; mem_wdata=0; beat counter=0; accumulator=0.
- Access size from funct3[1:0]: 00=1 byte, 01=2 bytes, 10=4 bytes.
- Legal funct3 values: loads 000, 001, 010, 100, 101; stores 000, 001, 010. Any other value is illegal.
- Misaligned condition: addr mod size != 0.
- Beat count: NB = max(1, size*8/MEM_W).
- Beat address: beat k uses req_addr + k*(MEM_W/8).
- Sub-word access with size*8 < MEM_W:
  - one beat at the MEM_W-aligned address;
  - stores place the data in the byte lane selected by addr LSBs; unused lanes are driven with a replicated copy of the data;
  - loads extract the selected lane.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Request accepted when req_valid && req_ready.
  - Accept cycle latches we, funct3, addr and wdata.
  - Illegal or misaligned request: go to RESP with err=1; no memory beat is issued.
  - Otherwise go to ACCESS with beat=0.
- ACCESS:
  - mem_req=1; mem_we, mem_addr and mem_wdata are held stable until mem_ack.
  - On mem_ack, read data is shifted into accumulator bits [beat*MEM_W +: MEM_W] and beat increments.
  - Last ack (beat==NB-1): go to RESP.
  - mem_req deasserts the cycle after the last ack.
- RESP:
  - resp_valid=1 for exactly one cycle.
  - resp_rdata is extended per funct3: 000 sign-8, 001 sign-16, 010 full, 100 zero-8, 101 zero-16.
  - Next state is IDLE.
- req_ready=1 only in IDLE. No request is accepted in RESP; this gives one bubble per access.
- Latency with zero-wait memory (mem_ack tied high):
  - accept at cycle 0, ACCESS for NB cycles, resp_valid at cycle NB+1;
  - error response at cycle 1.
- mem_ack outside ACCESS is ignored.
- req_* inputs are not sampled outside the accept cycle, so changing them mid-access has no effect.
- Reset mid-access: the next state is IDLE, mem_req drops at that edge, no resp_valid is generated, and the partial accumulator is discarded.
- Address arithmetic wraps modulo 2^ADDR_W.

Decomposition:
- Shared package rv_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - FSM enum lsu_state_t {IDLE, ACCESS, RESP};
  - function size_bytes(funct3);
  - function is_legal(we, funct3).
- One natural sub-module: rv_load_ext, a combinational extract-and-extend that takes the accumulator, the addr LSBs and funct3, and outputs XLEN data.
- The FSM, beat counter and accumulator stay in the top module.

Test Plan:
- MEM_W=8, zero-wait. LW addr=0x100, memory bytes 0x100..0x103 = 93,00,70,00 -> four mem_req beats at 0x100..0x103, then resp_rdata=0x00700093 with resp_valid at cycle 5.
- MEM_W=8. LB addr=0x201 with mem_rdata=0x80 -> resp_rdata=0xFFFFFF80. LBU at the same address -> 0x00000080.
- MEM_W=32. SH addr=0x002, wdata=0x0000BEEF -> a single beat at mem_addr=0x000 with mem_wdata[31:16]=0xBEEF, mem_we=1.
- LH addr=0x003 -> resp_err=1 at cycle 1, mem_req never asserted. Load with funct3=011 -> resp_err=1.
- MEM_W=16. LW with mem_ack held low 3 cycles per beat -> mem_addr/mem_wdata stable while waiting, 2 beats total, correct 32-bit result.
- Assert sysreset during beat 2 of an LW -> next cycle state=IDLE, mem_req=0, req_ready=1, no resp_valid. A subsequent LW completes normally.
